// File: rtl/scan_bus_sequencer.sv
`timescale 1ns/1ps
// scan_bus_sequencer: shares one output bus between an IN-12 anode/cathode
// display, a keyboard matrix scanner and an MS6205 write port, one column per Tick.
module scan_bus_sequencer #(
    parameter int COLUMNS       = 10,
    parameter int DATA_WIDTH    = 8,
    parameter int KB_ROWS       = 7,
    parameter int STROBE_CYCLES = 2,
    parameter int MS_TIMEOUT    = 255,
    localparam int COL_W = (COLUMNS > 1) ? $clog2(COLUMNS) : 1,
    localparam int ROW_W = (KB_ROWS > 1) ? $clog2(KB_ROWS) : 1
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  Tick,
    input  logic [DATA_WIDTH-1:0] cathode_data,
    input  logic                  ms_valid,
    input  logic [DATA_WIDTH-1:0] ms_addr,
    input  logic [DATA_WIDTH-1:0] ms_data,
    input  logic                  ms_ready,
    input  logic [KB_ROWS-1:0]    kb_row,
    output logic [COL_W-1:0]      column,
    output logic [DATA_WIDTH-1:0] bus_data,
    output logic [2:0]            phase,
    output logic                  in12_clear,
    output logic                  in12_write_anode,
    output logic                  in12_write_cathode,
    output logic                  kb_write,
    output logic                  kb_read,
    output logic                  kb_clear,
    output logic                  ms_write_addr,
    output logic                  ms_write_data,
    output logic                  ms_accept,
    output logic                  ms_error,
    output logic                  key_valid,
    output logic [COL_W-1:0]      key_col,
    output logic [ROW_W-1:0]      key_row,
    output logic                  busy,
    output logic                  overrun
);

    localparam int CNT_W  = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
    localparam int WAIT_W = (MS_TIMEOUT > 1) ? $clog2(MS_TIMEOUT) : 1;

    // Encodings double as the externally visible phase code.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CATHODE = 3'd1,
        S_ANODE   = 3'd2,
        S_KB      = 3'd3,
        S_MS_ADDR = 3'd4,
        S_MS_DATA = 3'd5,
        S_CLEAR   = 3'd6
    } state_e;

    state_e                         state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [WAIT_W-1:0]              wait_q, wait_d;
    logic [COL_W-1:0]               column_q, column_d, columnNext;
    logic [DATA_WIDTH-1:0]          cath_q, cath_d;
    logic [DATA_WIDTH-1:0]          msAddr_q, msAddr_d, msData_q, msData_d;
    logic [COLUMNS-1:0][KB_ROWS-1:0] sample_q, sample_d, kstate_q, kstate_d;
    logic                           msError_q, msError_d;
    logic                           overrun_q, overrun_d;
    logic                           keyValid_q, keyValid_d;
    logic [COL_W-1:0]               keyCol_q, keyCol_d;
    logic [ROW_W-1:0]               keyRow_q, keyRow_d;
    logic                           lastStrobe, timeoutHit;
    logic [KB_ROWS-1:0]             kbPrev, kbState, kbQual, kbRelease, kbStateNext;
    logic [ROW_W-1:0]               pressRow;

    assign lastStrobe = (cnt_q == CNT_W'(STROBE_CYCLES - 1));
    assign timeoutHit = (wait_q == WAIT_W'(MS_TIMEOUT - 1));
    assign columnNext = (column_q == COL_W'(COLUMNS - 1)) ? '0 : column_q + COL_W'(1);

    // Key debounce for the current column: a press needs two consecutive 1 samples, the lowest new row wins.
    always_comb begin
        kbPrev    = sample_q[column_q];
        kbState   = kstate_q[column_q];
        kbQual    = kb_row & kbPrev & ~kbState;
        kbRelease = ~kb_row & ~kbPrev;
        pressRow  = '0;
        for (int r = KB_ROWS - 1; r >= 0; r--) begin
            if (kbQual[r]) pressRow = ROW_W'(r);
        end
        kbStateNext = kbState & ~kbRelease;
        if (|kbQual) kbStateNext[pressRow] = 1'b1;
    end

    // Next-state logic: phase sequencing, MS6205 handshake with timeout, key event generation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wait_d     = wait_q;
        column_d   = column_q;
        cath_d     = cath_q;
        msAddr_d   = msAddr_q;
        msData_d   = msData_q;
        sample_d   = sample_q;
        kstate_d   = kstate_q;
        msError_d  = 1'b0;
        overrun_d  = Tick && (state_q != S_IDLE);
        keyValid_d = 1'b0;
        keyCol_d   = keyCol_q;
        keyRow_d   = keyRow_q;
        case (state_q)
            S_IDLE: begin
                if (Tick) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            S_CLEAR, S_ANODE, S_CATHODE: begin
                if (lastStrobe) begin
                    cnt_d = '0;
                    if (state_q == S_CLEAR) begin
                        state_d = S_ANODE;
                    end else if (state_q == S_ANODE) begin
                        state_d = S_CATHODE;
                        cath_d  = cathode_data;
                    end else begin
                        state_d = S_KB;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_KB: begin
                if (lastStrobe) begin
                    cnt_d              = '0;
                    sample_d[column_q] = kb_row;
                    kstate_d[column_q] = kbStateNext;
                    keyValid_d         = |kbQual;
                    if (|kbQual) begin
                        keyCol_d = column_q;
                        keyRow_d = pressRow;
                    end
                    if (ms_valid) begin
                        state_d  = S_MS_ADDR;
                        wait_d   = '0;
                        msAddr_d = ms_addr;
                        msData_d = ms_data;
                    end else begin
                        state_d  = S_IDLE;
                        column_d = columnNext;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_MS_ADDR, S_MS_DATA: begin
                if (ms_ready) begin
                    wait_d = '0;
                    if (lastStrobe) begin
                        cnt_d = '0;
                        if (state_q == S_MS_ADDR) begin
                            state_d = S_MS_DATA;
                        end else begin
                            state_d  = S_IDLE;
                            column_d = columnNext;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d = '0;
                    if (timeoutHit) begin
                        wait_d    = '0;
                        msError_d = 1'b1;
                        state_d   = S_IDLE;
                        column_d  = columnNext;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset clears the sequencer, the column pointer and all key history.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            wait_q     <= '0;
            column_q   <= '0;
            cath_q     <= '0;
            msAddr_q   <= '0;
            msData_q   <= '0;
            sample_q   <= '0;
            kstate_q   <= '0;
            msError_q  <= 1'b0;
            overrun_q  <= 1'b0;
            keyValid_q <= 1'b0;
            keyCol_q   <= '0;
            keyRow_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wait_q     <= wait_d;
            column_q   <= column_d;
            cath_q     <= cath_d;
            msAddr_q   <= msAddr_d;
            msData_q   <= msData_d;
            sample_q   <= sample_d;
            kstate_q   <= kstate_d;
            msError_q  <= msError_d;
            overrun_q  <= overrun_d;
            keyValid_q <= keyValid_d;
            keyCol_q   <= keyCol_d;
            keyRow_q   <= keyRow_d;
        end
    end

    // Strobe and bus decode; MS6205 strobes follow ms_ready directly so they never fire while it is low.
    always_comb begin
        in12_clear         = 1'b0;
        in12_write_anode   = 1'b0;
        in12_write_cathode = 1'b0;
        kb_write           = 1'b0;
        kb_read            = 1'b0;
        kb_clear           = 1'b0;
        ms_write_addr      = 1'b0;
        ms_write_data      = 1'b0;
        ms_accept          = 1'b0;
        bus_data           = '0;
        case (state_q)
            S_CLEAR: begin
                in12_clear = 1'b1;
                kb_clear   = 1'b1;
            end
            S_ANODE: begin
                in12_write_anode = 1'b1;
                bus_data         = {{(DATA_WIDTH - COL_W){1'b0}}, column_q};
            end
            S_CATHODE: begin
                in12_write_cathode = 1'b1;
                bus_data           = cath_q;
            end
            S_KB: begin
                bus_data = {{(DATA_WIDTH - COL_W){1'b0}}, column_q};
                if ((STROBE_CYCLES > 1) && (cnt_q == '0)) kb_write = 1'b1;
                else                                      kb_read  = 1'b1;
            end
            S_MS_ADDR: begin
                bus_data      = msAddr_q;
                ms_write_addr = ms_ready;
            end
            S_MS_DATA: begin
                bus_data      = msData_q;
                ms_write_data = ms_ready;
                ms_accept     = ms_ready && lastStrobe;
            end
            default: ;
        endcase
    end

    assign column    = column_q;
    assign phase     = state_q;
    assign busy      = (state_q != S_IDLE);
    assign ms_error  = msError_q;
    assign overrun   = overrun_q;
    assign key_valid = keyValid_q;
    assign key_col   = keyCol_q;
    assign key_row   = keyRow_q;

endmodule

// File: tb/tb_scan_bus_sequencer.sv
`timescale 1ns/1ps
// Directed bench for scan_bus_sequencer with default parameters.
module tb_scan_bus_sequencer;

    logic       Clk, Rst_n, Tick, ms_valid, ms_ready;
    logic [7:0] cathode_data, ms_addr, ms_data, bus_data;
    logic [6:0] kb_row;
    logic [3:0] column, key_col;
    logic [2:0] phase, key_row;
    logic       in12_clear, in12_write_anode, in12_write_cathode;
    logic       kb_write, kb_read, kb_clear, ms_write_addr, ms_write_data;
    logic       ms_accept, ms_error, key_valid, busy, overrun;
    logic [7:0] stb;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [3:0] expCol      = 4'd0;

    logic [2:0] expPh     [8] = '{3'd6, 3'd6, 3'd2, 3'd2, 3'd1, 3'd1, 3'd3, 3'd3};
    logic [6:0] kbRowsTab [8] = '{7'h05, 7'h05, 7'h05, 7'h05, 7'h00, 7'h00, 7'h01, 7'h01};
    logic       kbKvTab   [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [2:0] kbRowTab  [8] = '{3'd0, 3'd0, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};

    assign stb = {in12_clear, kb_clear, in12_write_anode, in12_write_cathode,
                  kb_write, kb_read, ms_write_addr, ms_write_data};

    scan_bus_sequencer dut (
        .Clk(Clk), .Rst_n(Rst_n), .Tick(Tick), .cathode_data(cathode_data),
        .ms_valid(ms_valid), .ms_addr(ms_addr), .ms_data(ms_data), .ms_ready(ms_ready),
        .kb_row(kb_row), .column(column), .bus_data(bus_data), .phase(phase),
        .in12_clear(in12_clear), .in12_write_anode(in12_write_anode),
        .in12_write_cathode(in12_write_cathode), .kb_write(kb_write), .kb_read(kb_read),
        .kb_clear(kb_clear), .ms_write_addr(ms_write_addr), .ms_write_data(ms_write_data),
        .ms_accept(ms_accept), .ms_error(ms_error), .key_valid(key_valid),
        .key_col(key_col), .key_row(key_row), .busy(busy), .overrun(overrun)
    );

    // Free-running 100 MHz clock.
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Watchdog so a stuck run still ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed running, expected done");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    // Move to the input drive point of the next cycle (just after the rising edge).
    task automatic applyStimulus();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [3:0] nextCol(input logic [3:0] c);
        return (c == 4'd9) ? 4'd0 : c + 4'd1;
    endfunction

    // One Tick-started scan through CLEAR..KB; returns after observing the last KB cycle.
    task automatic doScan(input logic [6:0] rows, input logic [7:0] cath, input bit injectTick);
        logic [7:0] expStb, expBus;
        applyStimulus();
        Tick = 1'b1; kb_row = rows; cathode_data = cath;
        for (int i = 0; i < 8; i++) begin
            applyStimulus();
            Tick = 1'b0;
            if (i == 5) cathode_data = ~cath;
            if (injectTick && i == 4) Tick = 1'b1;
            @(negedge Clk);
            case (i)
                0, 1:    begin expStb = 8'b1100_0000; expBus = 8'h00; end
                2, 3:    begin expStb = 8'b0010_0000; expBus = {4'b0, expCol}; end
                4, 5:    begin expStb = 8'b0001_0000; expBus = cath; end
                6:       begin expStb = 8'b0000_1000; expBus = {4'b0, expCol}; end
                default: begin expStb = 8'b0000_0100; expBus = {4'b0, expCol}; end
            endcase
            checkOutput("scan_phase", 32'(phase), 32'(expPh[i]));
            checkOutput("scan_busy", 32'(busy), 32'd1);
            checkOutput("scan_strobes", 32'(stb), 32'(expStb));
            checkOutput("scan_bus", 32'(bus_data), 32'(expBus));
            if (i == 0) checkOutput("scan_column", 32'(column), 32'(expCol));
            if (injectTick && i == 5) checkOutput("overrun_pulse", 32'(overrun), 32'd1);
            if (injectTick && i == 6) checkOutput("overrun_clear", 32'(overrun), 32'd0);
        end
    endtask

    // First cycle back in IDLE: column advanced, key event as expected.
    task automatic idleCheck(input logic expKv, input logic [2:0] expRow);
        logic [3:0] scanned;
        scanned = expCol;
        expCol  = nextCol(expCol);
        applyStimulus();
        @(negedge Clk);
        checkOutput("idle_phase", 32'(phase), 32'd0);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("idle_strobes", 32'(stb), 32'd0);
        checkOutput("idle_bus", 32'(bus_data), 32'd0);
        checkOutput("idle_column", 32'(column), 32'(expCol));
        checkOutput("key_valid", 32'(key_valid), 32'(expKv));
        if (expKv) begin
            checkOutput("key_col", 32'(key_col), 32'(scanned));
            checkOutput("key_row", 32'(key_row), 32'(expRow));
            applyStimulus();
            @(negedge Clk);
            checkOutput("key_valid_drop", 32'(key_valid), 32'd0);
        end
    endtask

    // Directed sequence.
    initial begin
        bit       early;
        int       visit;
        Rst_n = 1'b0; Tick = 1'b0; ms_valid = 1'b0; ms_ready = 1'b0;
        cathode_data = 8'h00; ms_addr = 8'h00; ms_data = 8'h00; kb_row = 7'h00;
        $display("[TB] start");

        // Reset state.
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        checkOutput("rst_phase", 32'(phase), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_column", 32'(column), 32'd0);
        checkOutput("rst_bus", 32'(bus_data), 32'd0);
        checkOutput("rst_strobes", 32'(stb), 32'd0);
        applyStimulus();
        Rst_n = 1'b1;

        // Column 0: plain scan.
        doScan(7'h00, 8'hA7, 1'b0);
        idleCheck(1'b0, 3'd0);

        // Column 1: Tick during CATHODE.
        doScan(7'h00, 8'h5C, 1'b1);
        idleCheck(1'b0, 3'd0);

        // Column 2: MS6205 write with ms_ready high.
        ms_valid = 1'b1; ms_addr = 8'h12; ms_data = 8'h34; ms_ready = 1'b1;
        doScan(7'h00, 8'h81, 1'b0);
        applyStimulus();
        @(negedge Clk);
        checkOutput("ms_a1_phase", 32'(phase), 32'd4);
        checkOutput("ms_a1_bus", 32'(bus_data), 32'h12);
        checkOutput("ms_a1_strobes", 32'(stb), 32'h02);
        checkOutput("ms_a1_accept", 32'(ms_accept), 32'd0);
        applyStimulus();
        ms_addr = 8'hFF; ms_data = 8'hEE;
        @(negedge Clk);
        checkOutput("ms_a2_bus", 32'(bus_data), 32'h12);
        checkOutput("ms_a2_strobes", 32'(stb), 32'h02);
        applyStimulus();
        @(negedge Clk);
        checkOutput("ms_d1_phase", 32'(phase), 32'd5);
        checkOutput("ms_d1_bus", 32'(bus_data), 32'h34);
        checkOutput("ms_d1_strobes", 32'(stb), 32'h01);
        checkOutput("ms_d1_accept", 32'(ms_accept), 32'd0);
        applyStimulus();
        @(negedge Clk);
        checkOutput("ms_d2_bus", 32'(bus_data), 32'h34);
        checkOutput("ms_d2_strobes", 32'(stb), 32'h01);
        checkOutput("ms_d2_accept", 32'(ms_accept), 32'd1);
        ms_valid = 1'b0;
        idleCheck(1'b0, 3'd0);

        // Keyboard: eight visits of column 3, other columns idle.
        visit = 0;
        for (int s = 0; s < 71; s++) begin
            if (expCol == 4'd3) begin
                doScan(kbRowsTab[visit], 8'(s) ^ 8'h3C, 1'b0);
                idleCheck(kbKvTab[visit], kbRowTab[visit]);
                visit++;
            end else begin
                doScan(7'h00, 8'(s), 1'b0);
                idleCheck(1'b0, 3'd0);
            end
        end
        checkOutput("kb_visits", 32'(visit), 32'd8);

        // Column 4: ms_ready never rises, request times out.
        ms_valid = 1'b1; ms_addr = 8'h77; ms_data = 8'h66; ms_ready = 1'b0;
        doScan(7'h00, 8'h0F, 1'b0);
        applyStimulus();
        @(negedge Clk);
        checkOutput("to_entry_phase", 32'(phase), 32'd4);
        checkOutput("to_entry_bus", 32'(bus_data), 32'h77);
        checkOutput("to_entry_strobes", 32'(stb), 32'd0);
        early = 1'b0;
        for (int k = 1; k < 255; k++) begin
            applyStimulus();
            @(negedge Clk);
            if (ms_error !== 1'b0 || ms_accept !== 1'b0 || phase !== 3'd4) early = 1'b1;
        end
        checkOutput("to_waiting", 32'(early), 32'd0);
        applyStimulus();
        ms_valid = 1'b0;
        @(negedge Clk);
        expCol = nextCol(expCol);
        checkOutput("to_error", 32'(ms_error), 32'd1);
        checkOutput("to_phase", 32'(phase), 32'd0);
        checkOutput("to_accept", 32'(ms_accept), 32'd0);
        checkOutput("to_column", 32'(column), 32'(expCol));
        applyStimulus();
        @(negedge Clk);
        checkOutput("to_error_drop", 32'(ms_error), 32'd0);

        // Column 5 follows the timed-out column.
        doScan(7'h00, 8'h99, 1'b0);
        idleCheck(1'b0, 3'd0);

        // Column 6: ms_ready glitch restarts the count, then reset during MS_DATA.
        ms_valid = 1'b1; ms_addr = 8'h5A; ms_data = 8'hA5; ms_ready = 1'b1;
        doScan(7'h00, 8'h44, 1'b0);
        applyStimulus();
        @(negedge Clk);
        checkOutput("gl_a1_strobes", 32'(stb), 32'h02);
        applyStimulus();
        ms_ready = 1'b0;
        @(negedge Clk);
        checkOutput("gl_a2_phase", 32'(phase), 32'd4);
        checkOutput("gl_a2_strobes", 32'(stb), 32'd0);
        applyStimulus();
        ms_ready = 1'b1;
        @(negedge Clk);
        checkOutput("gl_a3_strobes", 32'(stb), 32'h02);
        applyStimulus();
        @(negedge Clk);
        checkOutput("gl_a4_phase", 32'(phase), 32'd4);
        checkOutput("gl_a4_strobes", 32'(stb), 32'h02);
        applyStimulus();
        @(negedge Clk);
        checkOutput("gl_d1_phase", 32'(phase), 32'd5);
        checkOutput("gl_d1_bus", 32'(bus_data), 32'hA5);
        checkOutput("gl_d1_accept", 32'(ms_accept), 32'd0);
        Rst_n = 1'b0;
        #1;
        checkOutput("ar_phase", 32'(phase), 32'd0);
        checkOutput("ar_bus", 32'(bus_data), 32'd0);
        checkOutput("ar_strobes", 32'(stb), 32'd0);
        checkOutput("ar_accept", 32'(ms_accept), 32'd0);
        checkOutput("ar_busy", 32'(busy), 32'd0);
        checkOutput("ar_column", 32'(column), 32'd0);
        checkOutput("ar_keys", 32'({key_valid, key_col, key_row}), 32'd0);
        checkOutput("ar_pulses", 32'({ms_error, overrun}), 32'd0);
        @(posedge Clk);
        #1;
        checkOutput("ar_hold_accept", 32'(ms_accept), 32'd0);
        Rst_n = 1'b1;
        ms_valid = 1'b0;
        expCol = 4'd0;

        // First scan after reset is column 0.
        doScan(7'h00, 8'h3E, 1'b0);
        idleCheck(1'b0, 3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
